// File: rtl/voter_lookup_ctrl.sv
// Voter lookup sequencer: linear ID ROM search, flag RAM check,
// vote commit and full flag sweep. Owns all RAM address/write lines.
module voter_lookup_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int ID_W   = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ID_W-1:0]   id_in,
  input  logic              cast,
  input  logic              abort,
  input  logic              clear_all,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ID_W-1:0]   rom_dout,
  output logic [ADDR_W-1:0] flag_addr,
  output logic              flag_we,
  output logic              flag_din,
  input  logic              flag_dout,
  output logic              busy,
  output logic              done,
  output logic [1:0]        result,
  output logic [ADDR_W-1:0] match_addr,
  output logic              committed,
  output logic              cleared
);

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    FLAG_RD,
    FLAG_CHK,
    REPORT,
    HOLD,
    MARK,
    CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  localparam logic [1:0] RES_BLANK = 2'b00;
  localparam logic [1:0] RES_VALID = 2'b01;
  localparam logic [1:0] RES_VOTED = 2'b10;
  localparam logic [1:0] RES_NONE  = 2'b11;

  state_t state;
  state_t next;

  logic [ID_W-1:0]   id_q;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic              sweep_done;
  logic [1:0]        result_q;
  logic [ADDR_W-1:0] match_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] flag_addr_q;

  logic blank;
  logic hit;
  logic last_cmp;

  // rom_dout is only meaningful from the second SEARCH cycle on
  assign blank = (state == SEARCH) && !cmp_valid
              && (id_q == '1);
  assign hit = (state == SEARCH) && cmp_valid
            && (rom_dout == id_q);
  assign last_cmp = (state == SEARCH) && cmp_valid
                 && (cmp_addr == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (clear_all) begin
          next = CLEAR;
        end else if (start) begin
          next = SEARCH;
        end
      end
      SEARCH: begin
        if (blank) begin
          next = REPORT;
        end else if (hit) begin
          next = FLAG_RD;
        end else if (last_cmp) begin
          next = REPORT;
        end
      end
      FLAG_RD: next = FLAG_CHK;
      FLAG_CHK: next = REPORT;
      REPORT: begin
        if (result_q == RES_VALID) begin
          next = HOLD;
        end else begin
          next = IDLE;
        end
      end
      HOLD: begin
        if (abort) begin
          next = IDLE;
        end else if (cast) begin
          next = MARK;
        end
      end
      MARK: next = IDLE;
      CLEAR: begin
        if (sweep_done) begin
          next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q        <= '0;
      cmp_valid   <= 1'b0;
      cmp_addr    <= '0;
      sweep_done  <= 1'b0;
      result_q    <= RES_BLANK;
      match_q     <= '0;
      rom_addr_q  <= '0;
      flag_addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clear_all) begin
            flag_addr_q <= '0;
            sweep_done  <= 1'b0;
          end else if (start) begin
            id_q       <= id_in;
            rom_addr_q <= '0;
            cmp_valid  <= 1'b0;
            result_q   <= RES_BLANK;
            match_q    <= '0;
          end
        end
        SEARCH: begin
          cmp_valid <= 1'b1;
          cmp_addr  <= rom_addr_q;
          // stop issuing reads once the search exits or hits the end
          if (next == SEARCH && rom_addr_q != LAST) begin
            rom_addr_q <= rom_addr_q + 1'b1;
          end
          if (blank) begin
            result_q <= RES_BLANK;
          end else if (hit) begin
            match_q     <= cmp_addr;
            flag_addr_q <= cmp_addr;
          end else if (last_cmp) begin
            result_q <= RES_NONE;
          end
        end
        FLAG_CHK: begin
          result_q <= flag_dout ? RES_VOTED : RES_VALID;
        end
        CLEAR: begin
          if (!sweep_done) begin
            if (flag_addr_q == LAST) begin
              sweep_done <= 1'b1;
            end else begin
              flag_addr_q <= flag_addr_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == REPORT);
    flag_we   = 1'b0;
    flag_din  = 1'b0;
    committed = 1'b0;
    cleared   = 1'b0;
    unique case (state)
      MARK: begin
        flag_we   = 1'b1;
        flag_din  = 1'b1;
        committed = 1'b1;
      end
      CLEAR: begin
        flag_we = !sweep_done;
        cleared = sweep_done;
      end
      default: begin
      end
    endcase
  end

  assign rom_addr   = rom_addr_q;
  assign flag_addr  = flag_addr_q;
  assign result     = result_q;
  assign match_addr = match_q;

endmodule

// File: tb/tb_voter_lookup_ctrl.sv
// Directed bench for voter_lookup_ctrl (DEPTH=16) with
// behavioural ID ROM and flag RAM models.
module tb_voter_lookup_ctrl;

  localparam int AW = 10;
  localparam int DP = 16;
  localparam int IW = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] id_in;
  logic          cast;
  logic          abort;
  logic          clear_all;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_dout;
  logic [AW-1:0] flag_addr;
  logic          flag_we;
  logic          flag_din;
  logic          flag_dout;
  logic          busy;
  logic          done;
  logic [1:0]    result;
  logic [AW-1:0] match_addr;
  logic          committed;
  logic          cleared;

  logic [IW-1:0] rom [DP];
  bit            flags [DP];

  int checks = 0;
  int errs   = 0;

  voter_lookup_ctrl #(
    .ADDR_W(AW),
    .DEPTH (DP),
    .ID_W  (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .id_in     (id_in),
    .cast      (cast),
    .abort     (abort),
    .clear_all (clear_all),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .flag_addr (flag_addr),
    .flag_we   (flag_we),
    .flag_din  (flag_din),
    .flag_dout (flag_dout),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .match_addr(match_addr),
    .committed (committed),
    .cleared   (cleared)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_dout <= (rom_addr < AW'(DP)) ?
      rom[rom_addr[3:0]] : '0;
  end

  always @(posedge clk) begin
    if (flag_we && flag_addr < AW'(DP))
      flags[flag_addr[3:0]] <= flag_din;
    flag_dout <= flags[flag_addr[3:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  task automatic lookup(input string tag,
                        input logic [IW-1:0] id,
                        input int exp_cyc,
                        input logic [1:0] exp_res,
                        input logic [AW-1:0] exp_addr,
                        input int exp_max,
                        input bit inj);
    int cyc;
    int mx;
    bit we_seen;
    start = 1'b1;
    id_in = id;
    tick();
    start = 1'b0;
    id_in = '0;
    cyc = 1;
    mx = 0;
    we_seen = 0;
    while (!done && cyc < 64) begin
      if (int'(rom_addr) > mx) mx = int'(rom_addr);
      if (flag_we) we_seen = 1;
      if (inj && cyc == 3) begin
        start = 1'b1;
        id_in = 40'h0123456789;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (int'(rom_addr) > mx) mx = int'(rom_addr);
    check({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    if (exp_res == 2'b01 || exp_res == 2'b10)
      check({tag, "_addr"}, 64'(match_addr),
            64'(exp_addr));
    if (exp_max >= 0)
      check({tag, "_romax"}, 64'(mx), 64'(exp_max));
    check({tag, "_nowe"}, 64'(we_seen), 64'd0);
    tick();
    check({tag, "_done1"}, 64'(done), 64'd0);
    check({tag, "_busy"}, 64'(busy),
          64'(exp_res == 2'b01));
  endtask

  initial begin
    bit acc;
    for (int i = 0; i < DP; i++)
      rom[i] = 40'h9900000000 + 40'(i);
    rom[5] = 40'h0123456789;
    rom[3] = 40'h5555555555;
    rom[9] = 40'h5555555555;
    reset = 1'b1;
    start = 1'b0;
    id_in = '0;
    cast = 1'b0;
    abort = 1'b0;
    clear_all = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out", 64'({done, result, match_addr,
          committed, cleared, flag_we, flag_din}),
          64'd0);
    check("rst_addr", 64'({rom_addr, flag_addr}),
          64'd0);

    lookup("valid", 40'h0123456789, 10, 2'b01,
           10'd5, -1, 0);
    tick();
    check("hold_busy", 64'(busy), 64'd1);
    cast = 1'b1;
    tick();
    cast = 1'b0;
    check("mark", 64'({flag_we, flag_din, committed,
          flag_addr}), 64'({3'b111, 10'd5}));
    tick();
    check("mark_end", 64'({busy, flag_we, committed}),
          64'd0);
    check("flag5_set", 64'(flags[5]), 64'd1);

    lookup("voted", 40'h0123456789, 10, 2'b10,
           10'd5, -1, 0);
    lookup("absent", 40'hABCDEF0123, 18, 2'b11,
           10'd0, 15, 0);
    lookup("blank", 40'hFFFFFFFFFF, 2, 2'b00,
           10'd0, 0, 0);
    lookup("dup", 40'h5555555555, 8, 2'b01,
           10'd3, -1, 1);
    cast = 1'b1;
    abort = 1'b1;
    tick();
    cast = 1'b0;
    abort = 1'b0;
    check("abort_win", 64'({busy, flag_we, committed}),
          64'd0);
    tick();
    check("flag3_clr", 64'(flags[3]), 64'd0);

    clear_all = 1'b1;
    start = 1'b1;
    id_in = 40'h0123456789;
    tick();
    clear_all = 1'b0;
    start = 1'b0;
    acc = 0;
    for (int i = 0; i < DP; i++) begin
      check($sformatf("clr_wr%0d", i),
            64'({flag_we, flag_din, flag_addr}),
            64'({1'b1, 1'b0, 10'(i)}));
      if (done || cleared) acc = 1;
      tick();
    end
    check("clr_stray", 64'(acc), 64'd0);
    check("cleared", 64'({cleared, flag_we}),
          64'({1'b1, 1'b0}));
    tick();
    check("clr_end", 64'({busy, cleared}), 64'd0);
    check("flag5_zero", 64'(flags[5]), 64'd0);

    clear_all = 1'b1;
    tick();
    clear_all = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("rst7_pre", 64'({flag_we, flag_addr}),
          64'({1'b1, 10'd7}));
    reset = 1'b1;
    tick();
    check("rst7_out", 64'({busy, done, result,
          match_addr, committed, cleared, flag_we,
          flag_din}), 64'd0);
    check("rst7_addr", 64'({rom_addr, flag_addr}),
          64'd0);
    reset = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (flag_we || busy) acc = 1;
    end
    check("rst7_quiet", 64'(acc), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
